// File: rtl/rom_pkg.sv
// Shared widths, FSM state encoding and output buffer entry type for rom_reader.
package rom_pkg;

  localparam int unsigned ROM_DEPTH  = 256;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned IDX_W      = 8;
  localparam int unsigned CNT_W      = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } buf_entry_t;

endpackage

// File: rtl/rom_reader_fifo.sv
// Synchronous FIFO of data+last entries; a push is accepted while full if a pop
// happens on the same edge.
module rom_reader_fifo
  import rom_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  buf_entry_t wr_entry,
  input  logic       pop,
  output buf_entry_t rd_entry,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  buf_entry_t         mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]  count_q, count_d;
  logic               do_push_c, do_pop_c;

  assign full     = (count_q == FCNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign rd_entry = mem_q[rd_ptr_q];

  always_comb begin
    do_pop_c  = pop && !empty;
    do_push_c = push && (!full || do_pop_c);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + FCNT_W'(do_push_c) - FCNT_W'(do_pop_c);
    if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // Storage is cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) mem_q[wr_ptr_q] <= wr_entry;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rom_reader.sv
// Burst reader: streams word_count ROM words from base_addr into a ready/valid output.
// Optional ROM_READER_CHECKSUM_EN adds a running XOR of handshaken words on checksum.
module rom_reader
  import rom_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned ROM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef ROM_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fetch_c, pop_c, buf_full, buf_empty;
  buf_entry_t        head, wr_entry_c;
  logic              unused_base_c;

  assign unused_base_c = ^{base_addr[ADDR_W-1:10], base_addr[1:0]};

  assign rom_addr  = ADDR_W'({idx_q, 2'b00});
  assign out_valid = !buf_empty;
  assign out_data  = head.data;
  assign out_last  = head.last && !buf_empty;
  assign busy      = busy_q;
  assign done      = done_q;

  assign pop_c      = out_valid && out_ready;
  assign fetch_c    = (state_q == ST_FETCH) && (!buf_full || pop_c);
  assign wr_entry_c = '{last: (rem_q == CNT_W'(1)), data: rom_data};

  rom_reader_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fetch_c),
    .wr_entry (wr_entry_c),
    .pop      (pop_c),
    .rd_entry (head),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start && (word_count != '0)) state_d = ST_FETCH;
      ST_FETCH: if (fetch_c && (rem_q == CNT_W'(1))) state_d = ST_DRAIN;
      ST_DRAIN: if (pop_c && out_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Address stays on the last fetched word once the final fetch is issued.
  always_comb begin
    idx_d  = idx_q;
    rem_d  = rem_q;
    busy_d = busy_q;
    done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            idx_d  = base_addr[9:2];
            rem_d  = (word_count > CNT_W'(256)) ? CNT_W'(256) : word_count;
            busy_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (fetch_c) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q != CNT_W'(1))
            idx_d = (idx_q == IDX_W'(ROM_DEPTH - 1)) ? '0 : idx_q + IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        if (pop_c && out_last) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      rem_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      rem_q  <= rem_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

`ifdef ROM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == ST_IDLE) && start) csum_d = '0;
    else if (pop_c)                    csum_d = csum_q ^ out_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

endmodule

// File: doc/rom_reader.md
ROM_READER -- requirements
Module: rom_reader

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 4, output buffer entries (power of two, >=2).
REQ-002 SHALL have parameter ROM_DEPTH, default 256, ROM word count addressed.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a burst; sampled only in IDLE.
REQ-006 base_addr  input  32  burst start byte address; bits [1:0] ignored.
REQ-007 word_count  input  9  words to read, 0..256.
REQ-008 rom_addr  output  32  byte address to ROM; ROM returns data combinationally.
REQ-009 rom_data  input  32  ROM read data for rom_addr, same cycle.
REQ-010 out_data  output  32  buffered word at head of output stream.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_ready  input  1  consumer accepts word when out_valid && out_ready.
REQ-013 out_last  output  1  head word is final word of burst.
REQ-014 busy  output  1  burst in progress.
REQ-015 done  output  1  one-cycle pulse at burst completion.

Function
REQ-016 SHALL implement states IDLE, FETCH, DRAIN.
REQ-017 IDLE: start=1 and word_count!=0 -> FETCH; latch word index = base_addr[9:2], remaining = min(word_count,256); busy=1 next cycle.
REQ-018 IDLE: start=1 and word_count=0 -> stay IDLE, done pulses next cycle, no output words, busy stays 0.
REQ-019 FETCH: each cycle buffer not full (or popped same cycle), drive rom_addr = {22'b0, index, 2'b00}, push rom_data at the edge, index += 1, remaining -= 1.
REQ-020 Word index SHALL wrap 255 -> 0; rom_addr[31:10] and [1:0] always 0.
REQ-021 FETCH with remaining reaching 0 -> DRAIN; DRAIN -> IDLE when the last-tagged word is handshaken, with done=1 in that following cycle and busy=0.
REQ-022 Latency: start accepted at edge N -> first ROM access cycle N+1 -> out_valid at cycle N+2; sustained 1 word/cycle with out_ready=1.
REQ-023 out_data/out_last SHALL be stable while out_valid=1 and out_ready=0; no word dropped or duplicated.
REQ-024 Simultaneous push and pop on a full buffer SHALL be permitted.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 rom_addr SHALL hold its last value when no fetch occurs.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, empty buffer, out_valid=0, out_last=0, busy=0, done=0, rom_addr=0, out_data=0, aborting any burst.
REQ-028 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-029 With ROM_READER_CHECKSUM_EN defined: output checksum[31:0] SHALL equal XOR of all words handshaken out in the current burst, cleared to 0 on start acceptance and on reset, final when done pulses.
REQ-030 Without ROM_READER_CHECKSUM_EN: checksum port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package rom_pkg SHALL hold ROM_DEPTH, WORD_BYTES=4, ADDR_W=32, DATA_W=32 and the state enum.
REQ-032 Buffer SHALL be sub-module rom_reader_fifo (sync FIFO, full/empty flags, data+last per entry).

Verification (ROM preloaded mem[0..4]=1,2,3,4,5, mem[255]=0xFF)
REQ-033 base_addr=0x0, word_count=5, out_ready=1 -> out_data 1,2,3,4,5 on consecutive cycles, out_last on 5, done one cycle after.
REQ-034 base_addr=0x3FC, word_count=2 -> rom_addr 0x3FC then 0x000; out_data 0xFF,1.
REQ-035 base_addr=0x7 (low bits ignored), word_count=3, out_ready toggling 1/0 -> out_data 2,3,4 each held while stalled, none lost.
REQ-036 word_count=0 -> no out_valid, done pulse next cycle, busy stays 0.
REQ-037 rst_n low mid-burst after 2 words -> outputs reset immediately; new burst base 0x4 count 1 returns 2.
REQ-038 CHECKSUM_EN build, base 0x0 count 5 -> checksum=0x1 (1^2^3^4^5) at done.
